stage_2_nbool_pipe: RTL
=======================

// Module: stage_2_nbool_pipe
// PURPOSE
//  Registered, parametrised successor of the stage-2 encode/renorm step. One CDF
//  lane plus N_BOOL chained 50%-probability boolean lanes, all one-round renorm.
//  Adds a valid/ready handshake with a 2-entry skid buffer, a summed shift
//  count, and a sticky flag-order error. Sits between stage 1 (probability/LUT)
//  and stage 3 (low update / carry).
// PARAMETERS
//  RANGE_WIDTH   16  range/low datapath width
//  D_SIZE        5   width of one renorm shift count
//  SYMBOL_WIDTH  4   symbol width; only bit 0 is used by boolean lanes
//  N_BOOL        4   boolean lanes per beat, 1..8
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    synchronous, active-high
//  in_valid       in   1                    input beat valid
//  in_ready       out  1                    space for a beat
//  UU, VV         in   RANGE_WIDTH          scaled FL/FH from stage 1
//  in_range       in   RANGE_WIDTH          current range, normalised (MSB=1)
//  lut_u, lut_v   in   RANGE_WIDTH          4*(N-(s-1)) / 4*(N-s) terms
//  COMP_mux_1     in   1                    1: range=u-v, 0: range=in_range-v
//  symbols        in   N_BOOL*SYMBOL_WIDTH  lane k at [k*SW +: SW]
//  bool_flags     in   N_BOOL               lane k active; thermometer from bit 0
//  out_valid      out  1                    output beat valid
//  out_ready      in   1                    stage 3 accepts
//  u              out  RANGE_WIDTH+1        CDF u
//  out_range      out  RANGE_WIDTH          final normalised range
//  pre_low        out  N_BOOL*RANGE_WIDTH   lane k in_range-v
//  initial_range  out  N_BOOL*RANGE_WIDTH   range entering lane k
//  out_d          out  N_BOOL*D_SIZE        lane 0 = bool or CDF d; k>0 bool d
//  d_total        out  D_SIZE+3             sum of d over active lanes (or CDF d)
//  bool_out       out  N_BOOL               registered bool_flags
//  symbol_out     out  N_BOOL               symbol bit 0 per lane
//  COMP_mux_1_out out  1                    registered COMP_mux_1
//  flag_err       out  1                    sticky: non-thermometer flags accepted
// BEHAVIOUR
//  - Arithmetic is combinational on the input beat and registered at accept
//    (in_valid & in_ready). Latency: accept in cycle T gives out_valid in T+1.
//  - CDF: RR=in_range>>8; u=(RR*UU>>1)+lut_u; v=(RR*VV>>1)+lut_v (RW+1 bits).
//    raw=COMP?u-v:in_range-v on low RW bits; d=LZC(raw); range=raw<<d.
//  - Bool lane k: r_0=in_range, r_{k+1}=out_range_k; v=((r_k>>8)<<7)+4;
//    pre_low=r_k-v; raw=sym[0]?v:pre_low; d=raw[MSB]?0:raw[MSB-1]?1:2;
//    range=raw<<d. All lanes are computed; flags only select.
//  - out_range = range of highest active lane if bool_flags[0], else CDF range.
//    d_total = sum of out_d over active lanes, or CDF d if bool_flags[0]=0.
//  - Handshake: output reg plus skid reg. Output advances when
//    out_valid & out_ready, or !out_valid. in_ready=!skid_full, registered.
//    When the output is stalled, an accepted beat goes to skid. Skid drains to
//    output on the next output advance. No beat is dropped or duplicated.
//    Order is preserved.
//  - Simultaneous accept and output drain with skid full: skid moves to output,
//    and the new beat goes to skid. This is unreachable while in_ready=0.
//  - Outputs are held stable while out_valid & !out_ready.
//  - flag_err sets on accept of flags that are not 0..01..1. The beat still
//    passes, with out_range taken from the highest set bit. Cleared only by reset.
//  - Reset, including mid-stream: out_valid=0, skid empty, flag_err=0, and all
//    data outputs 0. in_ready=0 while reset=1 and 1 the cycle after. In-flight
//    beats are discarded.
// TESTING
//  - CDF beat: in_range=32768, UU=256, VV=128, lut_u=8, lut_v=4, COMP=1,
//    flags=0 -> u=16392, out_range=32784, out_d[0]=2, d_total=2, after 1 cycle.
//  - Bool lane 0 only: in_range=32768, sym0=0, flags=0001 -> pre_low[0]=16380,
//    out_range=65520, out_d[0]=2, d_total=2.
//  - Four bools: in_range=32768, sym=1,1,1,1, flags=1111 -> each lane d=1,
//    initial_range[1..3]=32776, out_range=32776, d_total=4.
//  - Backpressure: out_ready=0 for 3 cycles with in_valid=1. Exactly 2 beats
//    accepted, in_ready drops, outputs stable. Release gives beats in order.
//  - Flags=0101 -> flag_err=1 and stays 1. Out_range from lane 2. Reset -> 0.
//  - Reset asserted with both regs full -> next cycle out_valid=0, in_ready=1.
//    Also repeat the first three tests with N_BOOL=8 and N_BOOL=1.

Source files
------------

// File: rtl/stage_2_nbool_pipe.sv
// Stage-2 encode/renorm: one CDF lane plus N_BOOL chained 50% boolean lanes,
// registered behind a valid/ready handshake with a 2-entry (output + skid) buffer.
module stage_2_nbool_pipe #(
  parameter int RANGE_WIDTH  = 16,
  parameter int D_SIZE       = 5,
  parameter int SYMBOL_WIDTH = 4,
  parameter int N_BOOL       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [RANGE_WIDTH-1:0]           UU,
  input  logic [RANGE_WIDTH-1:0]           VV,
  input  logic [RANGE_WIDTH-1:0]           in_range,
  input  logic [RANGE_WIDTH-1:0]           lut_u,
  input  logic [RANGE_WIDTH-1:0]           lut_v,
  input  logic                             COMP_mux_1,
  input  logic [N_BOOL*SYMBOL_WIDTH-1:0]   symbols,
  input  logic [N_BOOL-1:0]                bool_flags,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RANGE_WIDTH:0]             u,
  output logic [RANGE_WIDTH-1:0]           out_range,
  output logic [N_BOOL*RANGE_WIDTH-1:0]    pre_low,
  output logic [N_BOOL*RANGE_WIDTH-1:0]    initial_range,
  output logic [N_BOOL*D_SIZE-1:0]         out_d,
  output logic [D_SIZE+2:0]                d_total,
  output logic [N_BOOL-1:0]                bool_out,
  output logic [N_BOOL-1:0]                symbol_out,
  output logic                             COMP_mux_1_out,
  output logic                             flag_err
);

  localparam int RW = RANGE_WIDTH;
  localparam int UW = RANGE_WIDTH + 1;
  localparam int TW = D_SIZE + 3;

  typedef struct packed {
    logic [UW-1:0]          u;
    logic [RW-1:0]          rng;
    logic [N_BOOL*RW-1:0]   pre_low;
    logic [N_BOOL*RW-1:0]   init_range;
    logic [N_BOOL*D_SIZE-1:0] d;
    logic [TW-1:0]          d_total;
    logic [N_BOOL-1:0]      flags;
    logic [N_BOOL-1:0]      sym;
    logic                   comp;
  } beat_t;

  function automatic logic [D_SIZE-1:0] lzc(input logic [RW-1:0] x);
    lzc = D_SIZE'(RW);
    for (int i = 0; i < RW; i++) begin
      if (x[i]) lzc = D_SIZE'(RW - 1 - i);
    end
  endfunction

  // ---------------- CDF lane ----------------
  logic [RW-1:0]   rr;
  logic [2*RW-1:0] prod_u, prod_v;
  logic [UW-1:0]   cdf_u;
  logic [RW-1:0]   cdf_v, cdf_raw, cdf_range;
  logic [D_SIZE-1:0] cdf_d;

  always_comb begin
    rr        = in_range >> 8;
    prod_u    = {{RW{1'b0}}, rr} * {{RW{1'b0}}, UU};
    prod_v    = {{RW{1'b0}}, rr} * {{RW{1'b0}}, VV};
    cdf_u     = UW'(prod_u >> 1) + {1'b0, lut_u};
    // Only the low RW bits of v ever reach the subtraction.
    cdf_v     = RW'(prod_v >> 1) + lut_v;
    cdf_raw   = COMP_mux_1 ? (cdf_u[RW-1:0] - cdf_v) : (in_range - cdf_v);
    cdf_d     = lzc(cdf_raw);
    cdf_range = cdf_raw << cdf_d;
  end

  // ---------------- Boolean lanes (all computed, flags only select) ----------------
  logic [N_BOOL*RW-1:0]     bool_pre, bool_init, bool_rng;
  logic [N_BOOL*D_SIZE-1:0] bool_d;
  logic [N_BOOL-1:0]        bool_sym;

  always_comb begin : bool_lanes
    logic [RW-1:0] r, v, pre, raw;
    logic [1:0]    bd;
    // NOTE: every comb output gets a default before any branch, so no latch is inferred.
    bool_pre  = '0;
    bool_init = '0;
    bool_rng  = '0;
    bool_d    = '0;
    bool_sym  = '0;
    r   = in_range;
    v   = '0;
    pre = '0;
    raw = '0;
    bd  = '0;
    for (int k = 0; k < N_BOOL; k++) begin
      bool_init[k*RW +: RW] = r;
      bool_sym[k]           = symbols[k*SYMBOL_WIDTH];
      v   = ((r >> 8) << 7) + RW'(4);
      pre = r - v;
      raw = bool_sym[k] ? v : pre;
      bd  = raw[RW-1] ? 2'd0 : (raw[RW-2] ? 2'd1 : 2'd2);
      bool_pre[k*RW +: RW]      = pre;
      bool_d[k*D_SIZE +: D_SIZE] = D_SIZE'(bd);
      r = raw << bd;
      bool_rng[k*RW +: RW]      = r;
    end
  end

  // Highest set flag wins, which also covers non-thermometer patterns.
  logic [RW-1:0]            sel_range;
  logic [TW-1:0]            d_sum;
  logic [N_BOOL*D_SIZE-1:0] lane_d;

  always_comb begin
    sel_range = cdf_range;
    d_sum     = TW'(cdf_d);
    lane_d    = bool_d;
    lane_d[D_SIZE-1:0] = bool_flags[0] ? bool_d[D_SIZE-1:0] : cdf_d;
    if (bool_flags[0]) begin
      d_sum = '0;
      for (int k = 0; k < N_BOOL; k++) begin
        if (bool_flags[k]) begin
          sel_range = bool_rng[k*RW +: RW];
          d_sum     = d_sum + TW'(bool_d[k*D_SIZE +: D_SIZE]);
        end
      end
    end
  end

  beat_t beat_in;

  always_comb begin
    beat_in            = '0;
    beat_in.u          = cdf_u;
    beat_in.rng        = sel_range;
    beat_in.pre_low    = bool_pre;
    beat_in.init_range = bool_init;
    beat_in.d          = lane_d;
    beat_in.d_total    = d_sum;
    beat_in.flags      = bool_flags;
    beat_in.sym        = bool_sym;
    beat_in.comp       = COMP_mux_1;
  end

  // ---------------- Handshake: output register + skid register ----------------
  beat_t out_q, skid_q;
  logic  out_valid_q, skid_full_q, in_ready_q, flag_err_q;
  logic  accept, advance, skid_full_next, flags_ok;

  assign accept         = in_valid & in_ready_q;
  assign advance        = ~out_valid_q | out_ready;
  assign skid_full_next = advance ? (skid_full_q & accept) : (skid_full_q | accept);
  assign flags_ok       = ((bool_flags & (bool_flags + N_BOOL'(1))) == '0);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      flag_err_q  <= 1'b0;
      out_q       <= '0;
    end else begin
      if (advance) begin
        if (skid_full_q) begin
          out_valid_q <= 1'b1;
          out_q       <= skid_q;
        end else begin
          out_valid_q <= accept;
          if (accept) out_q <= beat_in;
        end
      end
      skid_full_q <= skid_full_next;
      in_ready_q  <= ~skid_full_next;
      if (accept && !flags_ok) flag_err_q <= 1'b1;
    end
  end

  // NOTE: skid payload has no reset; skid_full_q alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept && (!advance || skid_full_q)) skid_q <= beat_in;
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign u              = out_q.u;
  assign out_range      = out_q.rng;
  assign pre_low        = out_q.pre_low;
  assign initial_range  = out_q.init_range;
  assign out_d          = out_q.d;
  assign d_total        = out_q.d_total;
  assign bool_out       = out_q.flags;
  assign symbol_out     = out_q.sym;
  assign COMP_mux_1_out = out_q.comp;
  assign flag_err       = flag_err_q;

endmodule
